tick_counter: RTL and testbench

TICK_COUNTER -- requirements
Module: tick_counter

---
 rtl/tick_counter.sv | 76 +++++++
 tb/tb_tick_counter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_counter.sv
// Prescaled up/down tick counter with wrap pulse and sticky overflow flag.
// Optional build macro: TICK_COUNTER_SAT_EN -- when defined, the counter
// saturates at its boundary instead of wrapping; ports are identical.
module tick_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 28
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [DIV_W-1:0] div_factor,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  logic [DIV_W-1:0] div_cnt;
  logic             step_c;
  logic             boundary_c;
  logic [WIDTH-1:0] count_step_c;

  // Step decode; >= lets a lowered div_factor fire without a full roll-over.
  always_comb begin
    step_c       = en && (div_cnt >= div_factor);
    boundary_c   = step_c && (up ? (count == CNT_MAX) : (count == CNT_MIN));
    count_step_c = up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
`ifdef TICK_COUNTER_SAT_EN
    if (boundary_c) begin
      count_step_c = count;
    end
`endif
  end

  // Counter, prescaler and flags; priority clear > load > step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      div_cnt <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      ovf     <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      div_cnt <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      div_cnt <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      tick <= step_c;
      wrap <= boundary_c;
      if (boundary_c) begin
        ovf <= 1'b1;
      end
      if (step_c) begin
        count   <= count_step_c;
        div_cnt <= '0;
      end else if (en) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter against a cycle-level reference model.
module tb_tick_counter;

  localparam int W    = 8;
  localparam int DW   = 28;
  localparam int MAXV = 255;
`ifdef TICK_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] div_factor = '0;
  logic          up = 1'b1;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  count;
  logic          tick;
  logic          wrap;
  logic          ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: counter value as an integer, prescaler progress.
  int m_count;
  int m_div;
  bit m_tick;
  bit m_wrap;
  bit m_ovf;

  tick_counter #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .resetn(resetn), .en(en), .div_factor(div_factor), .up(up),
    .clear(clear), .load(load), .load_val(load_val),
    .count(count), .tick(tick), .wrap(wrap), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_count = 0; m_div = 0; m_tick = 0; m_wrap = 0; m_ovf = 0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic cycle();
    bit stp;
    bit bnd;
    if (clear) begin
      model_reset();
    end else if (load) begin
      m_count = int'(load_val); m_div = 0; m_tick = 0; m_wrap = 0;
    end else begin
      stp = en && (m_div >= int'(div_factor));
      bnd = stp && (up ? (m_count == MAXV) : (m_count == 0));
      m_tick = stp;
      m_wrap = bnd;
      if (bnd) m_ovf = 1;
      if (stp) begin
        m_div = 0;
        if (!(bnd && SAT))
          m_count = up ? (m_count + 1) % (MAXV + 1) : (m_count + MAXV) % (MAXV + 1);
      end else if (en) begin
        m_div++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    n_checks++;
    if ({count, tick, wrap, ovf} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset: got count=%h tick=%b wrap=%b ovf=%b, want all 0", count, tick, wrap, ovf);
    end
  endtask

  task automatic test_basic_count();
    en = 1; up = 1; div_factor = DW'(3);
    resetn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      n_checks++;
      if (count !== W'(i / 4) || tick !== (i % 4 == 0) || wrap !== 1'b0 || ovf !== 1'b0) begin
        n_errors++;
        $display("FAIL basic cyc%0d: got count=%h tick=%b wrap=%b ovf=%b, want count=%h tick=%b wrap=0 ovf=0",
                 i, count, tick, wrap, ovf, W'(i / 4), (i % 4 == 0));
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [W-1:0] exp_c [3];
    bit           exp_w [3];
    exp_c[0] = 8'hFE; exp_c[1] = 8'hFF; exp_c[2] = SAT ? 8'hFF : 8'h00;
    exp_w[0] = 0;     exp_w[1] = 0;     exp_w[2] = 1;
    en = 1; up = 1; div_factor = '0; load_val = 8'hFE; load = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      load = 0;
      n_checks++;
      if (count !== exp_c[i] || wrap !== exp_w[i] || ovf !== exp_w[i] || tick !== (i != 0)) begin
        n_errors++;
        $display("FAIL wrap_up step%0d: got count=%h tick=%b wrap=%b ovf=%b, want count=%h tick=%b wrap=%b ovf=%b",
                 i, count, tick, wrap, ovf, exp_c[i], (i != 0), exp_w[i], exp_w[i]);
      end
    end
    en = 0;
    cycle();
    n_checks++;
    if (wrap !== 1'b0 || ovf !== 1'b1 || tick !== 1'b0 || count !== exp_c[2]) begin
      n_errors++;
      $display("FAIL ovf_sticky: got count=%h tick=%b wrap=%b ovf=%b, want count=%h tick=0 wrap=0 ovf=1",
               count, tick, wrap, ovf, exp_c[2]);
    end
  endtask

  task automatic test_wrap_down();
    clear = 1;
    cycle();
    clear = 0;
    n_checks++;
    if ({count, tick, wrap, ovf} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL clear: got count=%h tick=%b wrap=%b ovf=%b, want all 0", count, tick, wrap, ovf);
    end
    en = 1; up = 0; div_factor = '0;
    cycle();
    en = 0;
    n_checks++;
    if (count !== (SAT ? 8'h00 : 8'hFF) || wrap !== 1'b1 || ovf !== 1'b1 || tick !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_down: got count=%h tick=%b wrap=%b ovf=%b, want count=%h tick=1 wrap=1 ovf=1",
               count, tick, wrap, ovf, SAT ? 8'h00 : 8'hFF);
    end
  endtask

  task automatic test_priority();
    en = 1; up = 1; div_factor = '0;
    load = 1; load_val = 8'hFF;
    cycle();
    load = 0;
    cycle();
    clear = 1; load = 1; load_val = 8'h55;
    cycle();
    clear = 0;
    n_checks++;
    if ({count, tick, wrap, ovf} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL clear_over_load: got count=%h tick=%b wrap=%b ovf=%b, want all 0", count, tick, wrap, ovf);
    end
    load_val = 8'h33;
    cycle();
    load = 0;
    n_checks++;
    if (count !== 8'h33 || tick !== 1'b0 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL load_over_step: got count=%h tick=%b wrap=%b, want count=33 tick=0 wrap=0", count, tick, wrap);
    end
  endtask

  task automatic test_div_lower();
    clear = 1;
    cycle();
    clear = 0; en = 1; up = 1; div_factor = DW'(49);
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if (tick !== 1'b0 || count !== 8'h00) begin
        n_errors++;
        $display("FAIL div49 cyc%0d: got count=%h tick=%b, want count=00 tick=0", i, count, tick);
      end
    end
    div_factor = DW'(5);
    for (int k = 0; k < 12; k++) begin
      cycle();
      n_checks++;
      if (tick !== (k % 6 == 0) || count !== W'(1 + k / 6)) begin
        n_errors++;
        $display("FAIL div_lower k%0d: got count=%h tick=%b, want count=%h tick=%b",
                 k, count, tick, W'(1 + k / 6), (k % 6 == 0));
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1; up = 1; div_factor = DW'(2); load = 1; load_val = 8'h37;
    cycle();
    load = 0;
    cycle();
    cycle();
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({count, tick, wrap, ovf} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset: got count=%h tick=%b wrap=%b ovf=%b, want all 0", count, tick, wrap, ovf);
    end
    en = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (count !== 8'h00 || tick !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_after_reset cyc%0d: got count=%h tick=%b, want count=00 tick=0", i, count, tick);
      end
    end
    en = 1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_checks++;
      if (tick !== (k == 2 || k == 5) || count !== W'((k + 1) / 3)) begin
        n_errors++;
        $display("FAIL restart k%0d: got count=%h tick=%b, want count=%h tick=%b",
                 k, count, tick, W'((k + 1) / 3), (k == 2 || k == 5));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 9) < 8);
      up         = 1'($urandom_range(0, 1));
      clear      = ($urandom_range(0, 99) < 3);
      load       = ($urandom_range(0, 99) < 6);
      load_val   = W'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) div_factor = DW'($urandom_range(0, 5));
      cycle();
      n_checks++;
      if ({count, tick, wrap, ovf} !== {W'(m_count), m_tick, m_wrap, m_ovf}) begin
        n_errors++;
        $display("FAIL random cyc%0d: got count=%h tick=%b wrap=%b ovf=%b, want count=%h tick=%b wrap=%b ovf=%b",
                 i, count, tick, wrap, ovf, W'(m_count), m_tick, m_wrap, m_ovf);
      end
    end
    clear = 0; load = 0;
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_wrap_up();
    test_wrap_down();
    test_priority();
    test_div_lower();
    test_async_reset();
    div_factor = '0;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
